// File: rtl/matrix_loader.sv
// matrix_loader: allocates a matrix ID in the store, writes its dimensions, then streams row-major elements into it.
// Optional MATRIX_LOADER_CLEAR_EN zero-fills the full MAX_SIZE x MAX_SIZE area before the dimension write.
`default_nettype none

module matrix_loader #(
  parameter int MAX_SIZE = 5,
  parameter int DATA_W   = 32,
  parameter int ID_W     = 7,
  parameter int ALLOC_TO = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        m_in,
  input  logic [3:0]        n_in,
  input  logic              abort,
  input  logic              elem_valid,
  input  logic [DATA_W-1:0] elem_data,
  output logic              elem_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ID_W-1:0]   loaded_id,
  output logic              alloc_req,
  output logic [3:0]        alloc_m,
  output logic [3:0]        alloc_n,
  input  logic              alloc_valid,
  input  logic [ID_W-1:0]   alloc_id,
  output logic              dim_we,
  output logic [ID_W-1:0]   dim_write_id,
  output logic [3:0]        dim_write_m,
  output logic [3:0]        dim_write_n,
  output logic              write_en,
  output logic [ID_W-1:0]   id_w,
  output logic [3:0]        row_w,
  output logic [3:0]        col_w,
  output logic [DATA_W-1:0] data_in
);

  localparam int         TO_W = $clog2(ALLOC_TO);
  localparam logic [3:0] MAX4 = 4'(MAX_SIZE);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ALLOC  = 3'd1;
  localparam logic [2:0] ST_WAIT_A = 3'd2;
  localparam logic [2:0] ST_DIM    = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERR    = 3'd6;
`ifdef MATRIX_LOADER_CLEAR_EN
  localparam logic [2:0] ST_CLEAR  = 3'd7;
`endif

  logic [2:0]      state_q, state_d;
  logic [3:0]      m_q, m_d, n_q, n_d;
  logic [3:0]      row_q, row_d, col_q, col_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            dims_ok;

  assign dims_ok = (m_in >= 4'd1) && (m_in <= MAX4) && (n_in >= 4'd1) && (n_in <= MAX4);

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    n_d     = n_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (dims_ok) begin
            m_d     = m_in;
            n_d     = n_in;
            state_d = ST_ALLOC;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_ALLOC: begin
        cnt_d   = '0;
        row_d   = '0;
        col_d   = '0;
        state_d = ST_WAIT_A;
      end
      ST_WAIT_A: begin
        if (alloc_valid) begin
          id_d = alloc_id;
`ifdef MATRIX_LOADER_CLEAR_EN
          state_d = ST_CLEAR;
`else
          state_d = ST_DIM;
`endif
        end else if (cnt_q == TO_W'(ALLOC_TO - 1)) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef MATRIX_LOADER_CLEAR_EN
      // Sweep the whole MAX_SIZE square regardless of m/n so stale cells are wiped.
      ST_CLEAR: begin
        if (col_q == MAX4 - 4'd1) begin
          col_d = '0;
          if (row_q == MAX4 - 4'd1) state_d = ST_DIM;
          else                      row_d   = row_q + 4'd1;
        end else begin
          col_d = col_q + 4'd1;
        end
      end
`endif
      ST_DIM: begin
        row_d   = '0;
        col_d   = '0;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (elem_valid) begin
          if (col_q == n_q - 4'd1) begin
            col_d = '0;
            if (row_q == m_q - 4'd1) state_d = ST_DONE;
            else                     row_d   = row_q + 4'd1;
          end else begin
            col_d = col_q + 4'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      n_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      n_q     <= n_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
    end
  end

  // abort suppresses every strobe in the cycle it is seen.
  assign busy       = (state_q != ST_IDLE);
  assign alloc_req  = (state_q == ST_ALLOC) && !abort;
  assign dim_we     = (state_q == ST_DIM)   && !abort;
  assign done       = (state_q == ST_DONE)  && !abort;
  assign err        = (state_q == ST_ERR)   && !abort;
  assign elem_ready = (state_q == ST_DATA)  && !abort;
`ifdef MATRIX_LOADER_CLEAR_EN
  assign write_en   = (elem_valid && elem_ready) || ((state_q == ST_CLEAR) && !abort);
`else
  assign write_en   = elem_valid && elem_ready;
`endif
  assign data_in      = (state_q == ST_DATA) ? elem_data : '0;
  assign loaded_id    = id_q;
  assign id_w         = id_q;
  assign dim_write_id = id_q;
  assign row_w        = row_q;
  assign col_w        = col_q;
  assign alloc_m      = m_q;
  assign alloc_n      = n_q;
  assign dim_write_m  = m_q;
  assign dim_write_n  = n_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: directed checks of matrix_loader load, error, timeout, abort and reset behaviour.
`default_nettype none

module tb_matrix_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, elem_valid, alloc_valid;
  logic [3:0]  m_in, n_in;
  logic [31:0] elem_data, data_in;
  logic [6:0]  alloc_id, loaded_id, dim_write_id, id_w;
  logic        elem_ready, busy, done, err, alloc_req, dim_we, write_en;
  logic [3:0]  alloc_m, alloc_n, dim_write_m, dim_write_n, row_w, col_w;

  int n_cmp = 0;
  int n_bad = 0;
  int n_alloc = 0, n_dim = 0, n_done = 0, n_err = 0, n_wr = 0;
  int a0, d0, dn0, e0, w0, idx;

  matrix_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .m_in(m_in), .n_in(n_in), .abort(abort),
    .elem_valid(elem_valid), .elem_data(elem_data), .elem_ready(elem_ready), .busy(busy),
    .done(done), .err(err), .loaded_id(loaded_id), .alloc_req(alloc_req), .alloc_m(alloc_m),
    .alloc_n(alloc_n), .alloc_valid(alloc_valid), .alloc_id(alloc_id), .dim_we(dim_we),
    .dim_write_id(dim_write_id), .dim_write_m(dim_write_m), .dim_write_n(dim_write_n),
    .write_en(write_en), .id_w(id_w), .row_w(row_w), .col_w(col_w), .data_in(data_in)
  );

  always #5 clk = ~clk;

  // Strobe tally; element writes are told apart from clear writes by nonzero data.
  always @(negedge clk) begin
    if (rst_n) begin
      if (alloc_req) n_alloc++;
      if (dim_we) n_dim++;
      if (done) n_done++;
      if (err) n_err++;
      if (write_en && data_in != 32'd0) n_wr++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap;
    a0 = n_alloc; d0 = n_dim; dn0 = n_done; e0 = n_err; w0 = n_wr;
  endtask

  task automatic do_alloc(input logic [3:0] m, input logic [3:0] n, input logic [6:0] id);
    start = 1'b1; m_in = m; n_in = n;
    tick;
    start = 1'b0;
    #1;
    check("alloc_req", alloc_req, 1);
    check("alloc_m", alloc_m, m);
    check("alloc_n", alloc_n, n);
    tick;
    alloc_valid = 1'b1; alloc_id = id;
    #1;
    check("wait_no_dim", dim_we, 0);
    tick;
    alloc_valid = 1'b0; alloc_id = '0;
`ifdef MATRIX_LOADER_CLEAR_EN
    for (int i = 0; i < 25; i++) begin
      #1;
      check("clr_we", write_en, 1);
      check("clr_data", data_in, 0);
      check("clr_row", row_w, i / 5);
      check("clr_col", col_w, i % 5);
      check("clr_id", id_w, id);
      tick;
    end
`endif
    #1;
    check("dim_we", dim_we, 1);
    check("dim_id", dim_write_id, id);
    check("dim_m", dim_write_m, m);
    check("dim_n", dim_write_n, n);
    tick;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; m_in = '0; n_in = '0; abort = 1'b0;
    elem_valid = 1'b0; elem_data = '0; alloc_valid = 1'b0; alloc_id = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_alloc", alloc_req, 0);
    check("rst_dim", dim_we, 0);
    check("rst_we", write_en, 0);
    check("rst_ready", elem_ready, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_id", loaded_id, 0);
    check("rst_m", alloc_m, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick;

    // 2x3 load, elements 1..6 back-to-back, ID 4
    snap;
    do_alloc(4'd2, 4'd3, 7'd4);
    elem_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      elem_data = 32'(k + 1);
      #1;
      check("t1_we", write_en, 1);
      check("t1_row", row_w, k / 3);
      check("t1_col", col_w, k % 3);
      check("t1_data", data_in, k + 1);
      check("t1_idw", id_w, 4);
      tick;
    end
    elem_valid = 1'b0;
    #1;
    check("t1_done", done, 1);
    check("t1_ready_off", elem_ready, 0);
    tick;
    check("t1_done_off", done, 0);
    check("t1_idle", busy, 0);
    check("t1_id", loaded_id, 4);
    check("t1_nalloc", n_alloc - a0, 1);
    check("t1_ndim", n_dim - d0, 1);
    check("t1_nwr", n_wr - w0, 6);
    check("t1_ndone", n_done - dn0, 1);

    // Illegal dimensions
    snap;
    start = 1'b1; m_in = 4'd0; n_in = 4'd3;
    tick;
    start = 1'b0;
    #1;
    check("t2a_err", err, 1);
    check("t2a_noalloc", alloc_req, 0);
    tick;
    check("t2a_idle", busy, 0);
    start = 1'b1; m_in = 4'd6; n_in = 4'd2;
    tick;
    start = 1'b0;
    #1;
    check("t2b_err", err, 1);
    tick;
    check("t2b_idle", busy, 0);
    check("t2_nalloc", n_alloc - a0, 0);
    check("t2_nerr", n_err - e0, 2);
    check("t2_id", loaded_id, 4);

    // Allocation timeout: 16 cycles in WAIT_A
    snap;
    start = 1'b1; m_in = 4'd2; n_in = 4'd2;
    tick;
    start = 1'b0;
    #1;
    check("t3_alloc", alloc_req, 1);
    tick;
    repeat (15) tick;
    check("t3_no_err_yet", err, 0);
    check("t3_busy", busy, 1);
    tick;
    check("t3_err", err, 1);
    tick;
    check("t3_idle", busy, 0);
    check("t3_id_kept", loaded_id, 4);
    check("t3_nerr", n_err - e0, 1);
    do_alloc(4'd1, 4'd2, 7'd9);
    elem_valid = 1'b1; elem_data = 32'hA;
    #1;
    check("t3_w0", write_en, 1);
    tick;
    elem_data = 32'hB;
    #1;
    check("t3_w1_col", col_w, 1);
    tick;
    elem_valid = 1'b0;
    #1;
    check("t3_done", done, 1);
    tick;
    check("t3_id", loaded_id, 9);

    // 3x3 with elem_valid toggling
    snap;
    do_alloc(4'd3, 4'd3, 7'd5);
    idx = 0;
    for (int c = 0; c < 17; c++) begin
      if (c % 2 == 0) begin
        elem_valid = 1'b1; elem_data = 32'h100 + 32'(idx + 1);
        #1;
        check("t4_we", write_en, 1);
        check("t4_row", row_w, idx / 3);
        check("t4_col", col_w, idx % 3);
        check("t4_data", data_in, 32'h100 + 32'(idx + 1));
        idx++;
      end else begin
        elem_valid = 1'b0;
        #1;
        check("t4_stall_we", write_en, 0);
        check("t4_stall_ready", elem_ready, 1);
      end
      tick;
    end
    elem_valid = 1'b0;
    #1;
    check("t4_done", done, 1);
    tick;
    check("t4_nwr", n_wr - w0, 9);
    check("t4_ndone", n_done - dn0, 1);

    // Same pattern, abort on the 5th element
    snap;
    do_alloc(4'd3, 4'd3, 7'd6);
    for (int c = 0; c < 8; c++) begin
      elem_valid = (c % 2 == 0);
      elem_data = 32'h201 + 32'(c / 2);
      tick;
    end
    elem_valid = 1'b1; elem_data = 32'h205; abort = 1'b1;
    #1;
    check("t5_abort_we", write_en, 0);
    check("t5_abort_ready", elem_ready, 0);
    check("t5_abort_done", done, 0);
    tick;
    abort = 1'b0; elem_valid = 1'b0;
    #1;
    check("t5_idle", busy, 0);
    check("t5_ready_off", elem_ready, 0);
    tick;
    tick;
    check("t5_nwr", n_wr - w0, 4);
    check("t5_ndone", n_done - dn0, 0);
    check("t5_nerr", n_err - e0, 0);

    // Reset asserted mid-DATA
    do_alloc(4'd2, 4'd2, 7'd7);
    elem_valid = 1'b1; elem_data = 32'h301;
    #1;
    check("t6_we", write_en, 1);
    tick;
    elem_data = 32'h302;
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_we", write_en, 0);
    check("t6_rst_ready", elem_ready, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_id", loaded_id, 0);
    check("t6_rst_m", alloc_m, 0);
    elem_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    tick;

    // 1x1 load after reset release
    snap;
    do_alloc(4'd1, 4'd1, 7'd3);
    elem_valid = 1'b1; elem_data = 32'hDEADBEEF;
    #1;
    check("t7_we", write_en, 1);
    check("t7_row", row_w, 0);
    check("t7_col", col_w, 0);
    check("t7_data", data_in, 32'hDEADBEEF);
    tick;
    elem_valid = 1'b0;
    #1;
    check("t7_done", done, 1);
    tick;
    check("t7_idle", busy, 0);
    check("t7_id", loaded_id, 3);
    check("t7_nwr", n_wr - w0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
